// File: rtl/load_pkg.sv
// load_pkg: shared size/state enums and exception codes for the load path.
package load_pkg;
  typedef enum logic [1:0] {LD_RSV = 2'b00, LD_BYTE = 2'b01, LD_HALF = 2'b10, LD_WORD = 2'b11} ld_size_t;
  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_SIZE     = 2'd2;
  localparam logic [1:0] EXC_TIMEOUT  = 2'd3;
  typedef enum logic [1:0] {
    IDLE,
    REQ,
`ifdef LOAD_MISALIGN_SPLIT_EN
    REQ_HI,
`endif
    DONE
  } ld_state_t;
endpackage

// File: rtl/load_extract.sv
// load_extract: selects the addressed byte/half/word of a little-endian word and zero/sign-extends it.
module load_extract
  import load_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]             raw,
  input  logic [$clog2(DATA_W/8)-1:0]   offset,
  input  ld_size_t                      size,
  input  logic                          sign_ext,
  output logic [DATA_W-1:0]             value
);
  logic [$clog2(DATA_W)-1:0] bit_idx;
  logic [7:0]                b;
  logic [15:0]               h;
  assign bit_idx = {offset, 3'b000};
  assign b       = raw[bit_idx +: 8];
  assign h       = raw[bit_idx +: 16];
  always_comb
    value = size == LD_BYTE ? {{(DATA_W-8){sign_ext & b[7]}}, b} :
            size == LD_HALF ? {{(DATA_W-16){sign_ext & h[15]}}, h} : raw;
endmodule

// File: rtl/load_align_unit.sv
// load_align_unit: word-aligned memory load with byte/half/word extract, timeout and exception reporting.
// LOAD_MISALIGN_SPLIT_EN: misaligned accesses are served with one or two reads instead of raising code 1.
module load_align_unit
  import load_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_start,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              ld_busy,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_exc,
  output logic [1:0]        ld_exc_code
);
  localparam int LANES = DATA_W / 8;
  localparam int OW    = $clog2(LANES);
  localparam int CW    = $clog2(TIMEOUT + 2);
  ld_state_t         state;
  ld_size_t          size, req_size;
  logic [OW-1:0]     off, req_off, ext_off;
  logic              sgn, tmo;
  logic [1:0]        code;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] lo, raw, ext;
  assign req_size = ld_size_t'(ld_size);
  assign req_off  = ld_addr[OW-1:0];
  assign tmo      = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
`ifdef LOAD_MISALIGN_SPLIT_EN
  logic              need_hi, req_cross;
  logic [DATA_W-1:0] hi;
  logic [OW+2:0]     sh;
  assign req_cross = int'(req_off) + (req_size == LD_BYTE ? 1 : req_size == LD_HALF ? 2 : LANES) > LANES;
  assign sh        = {off, 3'b000};
  // shifting hi by DATA_W when aligned yields zero, so one expression covers both cases
  assign raw       = (lo >> sh) | (hi << (DATA_W - int'(sh)));
  assign ext_off   = '0;
`else
  logic illegal;
  assign illegal = (req_size == LD_HALF && req_off[0]) || (req_size == LD_WORD && req_off != '0);
  assign raw     = lo;
  assign ext_off = off;
`endif
  load_extract #(.DATA_W(DATA_W)) u_extract (
    .raw     (raw),
    .offset  (ext_off),
    .size    (size),
    .sign_ext(sgn),
    .value   (ext)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      size        <= LD_RSV;
      off         <= '0;
      sgn         <= 1'b0;
      code        <= EXC_NONE;
      cnt         <= '0;
      lo          <= '0;
`ifdef LOAD_MISALIGN_SPLIT_EN
      hi          <= '0;
      need_hi     <= 1'b0;
`endif
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      ld_busy     <= 1'b0;
      ld_done     <= 1'b0;
      ld_data     <= '0;
      ld_exc      <= 1'b0;
      ld_exc_code <= EXC_NONE;
    end else begin
      ld_done <= 1'b0;
      case (state)
        IDLE: if (ld_start) begin
          mem_addr <= {ld_addr[ADDR_W-1:OW], {OW{1'b0}}};
          off      <= req_off;
          size     <= req_size;
          sgn      <= ld_signed;
          cnt      <= '0;
          ld_busy  <= 1'b1;
          if (req_size == LD_RSV) begin
            code  <= EXC_SIZE;
            state <= DONE;
`ifndef LOAD_MISALIGN_SPLIT_EN
          end else if (illegal) begin
            code  <= EXC_MISALIGN;
            state <= DONE;
`endif
          end else begin
            code   <= EXC_NONE;
            mem_rd <= 1'b1;
            state  <= REQ;
`ifdef LOAD_MISALIGN_SPLIT_EN
            need_hi <= req_cross;
`endif
          end
        end
        REQ: if (mem_ack) begin
          lo  <= mem_rdata;
          cnt <= '0;
`ifdef LOAD_MISALIGN_SPLIT_EN
          if (need_hi) begin
            mem_addr <= mem_addr + ADDR_W'(LANES);
            state    <= REQ_HI;
          end else begin
            mem_rd <= 1'b0;
            state  <= DONE;
          end
`else
          mem_rd <= 1'b0;
          state  <= DONE;
`endif
        end else if (tmo) begin
          code   <= EXC_TIMEOUT;
          mem_rd <= 1'b0;
          state  <= DONE;
        end else cnt <= cnt + 1'b1;
`ifdef LOAD_MISALIGN_SPLIT_EN
        REQ_HI: if (mem_ack) begin
          hi     <= mem_rdata;
          mem_rd <= 1'b0;
          state  <= DONE;
        end else if (tmo) begin
          code   <= EXC_TIMEOUT;
          mem_rd <= 1'b0;
          state  <= DONE;
        end else cnt <= cnt + 1'b1;
`endif
        DONE: begin
          state       <= IDLE;
          ld_busy     <= 1'b0;
          ld_done     <= 1'b1;
          ld_exc_code <= code;
          ld_exc      <= code != EXC_NONE;
          if (code == EXC_NONE) ld_data <= ext;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: scoreboard bench for load_align_unit (default and LOAD_MISALIGN_SPLIT_EN builds).
module tb_load_align_unit;
  logic        clk = 1'b0, reset, ld_start, ld_signed, mem_rd, mem_ack, ld_busy, ld_done, ld_exc;
  logic [1:0]  ld_size, ld_exc_code;
  logic [31:0] ld_addr, mem_addr, mem_rdata, ld_data;
  typedef struct {logic [31:0] data; logic [1:0] code;} exp_t;
  exp_t        sb[$];
  exp_t        got;
  int          checks = 0, passed = 0, done_cnt = 0;
  logic [31:0] last_data = '0;

  load_align_unit dut (
    .clk(clk), .reset(reset), .ld_start(ld_start), .ld_size(ld_size), .ld_signed(ld_signed),
    .ld_addr(ld_addr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ld_busy(ld_busy), .ld_done(ld_done), .ld_data(ld_data), .ld_exc(ld_exc), .ld_exc_code(ld_exc_code)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always @(negedge clk) if (!reset && ld_done) begin
    done_cnt++;
    checks++;
    if (sb.size() == 0) $display("FAIL sb_unexpected_done: got data=%h code=%0d, want no completion", ld_data, ld_exc_code);
    else begin
      got = sb.pop_front();
      if ({ld_data, ld_exc_code, ld_exc} !== {got.data, got.code, got.code != 2'd0})
        $display("FAIL sb_result: got data=%h code=%0d exc=%0b, want data=%h code=%0d exc=%0b",
                 ld_data, ld_exc_code, ld_exc, got.data, got.code, got.code != 2'd0);
      else passed++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [1:0] c);
    exp_t e;
    e.data    = (c == 2'd0) ? d : last_data;
    e.code    = c;
    last_data = e.data;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [1:0] s, input logic g, input logic [31:0] a);
    ld_start = 1'b1; ld_size = s; ld_signed = g; ld_addr = a;
    tick;
    ld_start = 1'b0;
  endtask

  task automatic respond(input int waits, input logic [31:0] d);
    repeat (waits) tick;
    mem_ack = 1'b1; mem_rdata = d;
    tick;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (ld_done !== 1'b1 && lat < 40) begin
      tick;
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; ld_start = 0; ld_size = 0; ld_signed = 0; ld_addr = 0; mem_ack = 0; mem_rdata = 0;
    tick; tick;
    checks++; if ({mem_rd, mem_addr, ld_busy, ld_done, ld_data, ld_exc, ld_exc_code} !== 69'd0)
      $display("FAIL reset_outputs: got %h, want 0", {mem_rd, mem_addr, ld_busy, ld_done, ld_data, ld_exc, ld_exc_code}); else passed++;
    reset = 1'b0;
    tick;
    checks++; if ({mem_rd, ld_busy, ld_done} !== 3'b000)
      $display("FAIL reset_release: got %b, want 000", {mem_rd, ld_busy, ld_done}); else passed++;
  endtask

  task automatic test_extract;
    logic [1:0]  sz[6] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b11, 2'b01};
    logic        sg[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] ad[6] = '{32'h1003, 32'h2002, 32'h0006, 32'h0005, 32'h0008, 32'h0000};
    int          wt[6] = '{0, 3, 1, 2, 0, 0};
    logic [31:0] rd[6] = '{32'h80FF_1234, 32'hBEEF_0000, 32'h8001_5555, 32'h0000_9A00, 32'h8765_4321, 32'h0000_007F};
    logic [31:0] ex[6] = '{32'hFFFF_FF80, 32'h0000_BEEF, 32'hFFFF_8001, 32'h0000_009A, 32'h8765_4321, 32'h0000_007F};
    int lat, d0;
    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      push_exp(ex[i], 2'd0);
      issue(sz[i], sg[i], ad[i]);
      checks++; if ({mem_rd, ld_busy, mem_addr} !== {2'b11, ad[i] & 32'hFFFF_FFFC})
        $display("FAIL extract%0d_req: got rd/busy/addr=%b/%h, want 11/%h", i, {mem_rd, ld_busy}, mem_addr, ad[i] & 32'hFFFF_FFFC); else passed++;
      respond(wt[i], rd[i]);
      wait_done(lat);
      checks++; if (lat + wt[i] + 1 !== wt[i] + 2)
        $display("FAIL extract%0d_latency: got %0d, want %0d", i, lat + wt[i] + 1, wt[i] + 2); else passed++;
      tick;
      checks++; if (done_cnt - d0 !== 1)
        $display("FAIL extract%0d_done_count: got %0d, want 1", i, done_cnt - d0); else passed++;
    end
  endtask

  task automatic test_misalign;
    int lat;
`ifdef LOAD_MISALIGN_SPLIT_EN
    push_exp(32'h5544_3322, 2'd0);
    issue(2'b11, 1'b0, 32'h0001);
    checks++; if ({mem_rd, mem_addr} !== {1'b1, 32'h0}) $display("FAIL split_lo_req: got %b/%h, want 1/00000000", mem_rd, mem_addr); else passed++;
    respond(0, 32'h4433_2211);
    checks++; if ({mem_rd, mem_addr} !== {1'b1, 32'h4}) $display("FAIL split_hi_req: got %b/%h, want 1/00000004", mem_rd, mem_addr); else passed++;
    respond(1, 32'h8877_6655);
    wait_done(lat);
    checks++; if (lat !== 1) $display("FAIL split_latency: got %0d, want 1", lat); else passed++;
    tick;
    push_exp(32'hFFFF_BBAA, 2'd0);
    issue(2'b10, 1'b1, 32'h0003);
    respond(0, 32'hAA00_0000);
    respond(0, 32'h0000_00BB);
    wait_done(lat);
    checks++; if (lat !== 1) $display("FAIL split_half_latency: got %0d, want 1", lat); else passed++;
    tick;
`else
    logic [1:0]  sz[2] = '{2'b11, 2'b10};
    logic [31:0] ad[2] = '{32'h0001, 32'h0003};
    for (int i = 0; i < 2; i++) begin
      push_exp(32'h0, 2'd1);
      issue(sz[i], 1'b0, ad[i]);
      checks++; if ({mem_rd, ld_busy} !== 2'b01) $display("FAIL misalign%0d_no_read: got rd/busy=%b, want 01", i, {mem_rd, ld_busy}); else passed++;
      wait_done(lat);
      checks++; if (lat !== 1) $display("FAIL misalign%0d_latency: got %0d, want 1", i, lat); else passed++;
      tick;
    end
`endif
  endtask

  task automatic test_reserved;
    int lat;
    push_exp(32'h0, 2'd2);
    issue(2'b00, 1'b1, 32'h0010);
    checks++; if (mem_rd !== 1'b0) $display("FAIL reserved_no_read: got mem_rd=%b, want 0", mem_rd); else passed++;
    wait_done(lat);
    checks++; if (lat !== 1) $display("FAIL reserved_latency: got %0d, want 1", lat); else passed++;
    tick;
  endtask

  task automatic test_timeout;
    int lat;
    push_exp(32'h0, 2'd3);
    issue(2'b11, 1'b0, 32'h0040);
    repeat (14) tick;
    checks++; if (mem_rd !== 1'b1) $display("FAIL timeout_rd_held: got %b, want 1", mem_rd); else passed++;
    tick;
    checks++; if ({mem_rd, ld_done} !== 2'b00) $display("FAIL timeout_rd_drop: got rd/done=%b, want 00", {mem_rd, ld_done}); else passed++;
    wait_done(lat);
    checks++; if (lat !== 1) $display("FAIL timeout_latency: got %0d, want 1", lat); else passed++;
    tick;
    push_exp(32'h1357_9BDF, 2'd0);
    issue(2'b11, 1'b1, 32'h0080);
    respond(14, 32'h1357_9BDF);
    wait_done(lat);
    checks++; if (lat !== 1) $display("FAIL ack_at_timeout_latency: got %0d, want 1", lat); else passed++;
    tick;
  endtask

  task automatic test_back_to_back;
    int lat, d0;
    logic [31:0] prev;
    prev = last_data;
    d0 = done_cnt;
    push_exp(32'hCAFE_F00D, 2'd0);
    issue(2'b11, 1'b0, 32'h0010);
    tick;
    issue(2'b01, 1'b1, 32'h0021);
    checks++; if ({mem_addr, ld_data, ld_busy} !== {32'h10, prev, 1'b1})
      $display("FAIL busy_ignore: got addr=%h data=%h busy=%b, want 00000010/%h/1", mem_addr, ld_data, ld_busy, prev); else passed++;
    respond(1, 32'hCAFE_F00D);
    wait_done(lat);
    checks++; if (lat !== 1) $display("FAIL busy_latency: got %0d, want 1", lat); else passed++;
    repeat (4) tick;
    checks++; if (done_cnt - d0 !== 1) $display("FAIL busy_done_count: got %0d, want 1", done_cnt - d0); else passed++;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick; tick;
    mem_ack = 1'b0;
    checks++; if ({mem_rd, ld_busy, ld_done, ld_data} !== {3'b000, last_data})
      $display("FAIL idle_ack_ignored: got %b/%h, want 000/%h", {mem_rd, ld_busy, ld_done}, ld_data, last_data); else passed++;
  endtask

  task automatic test_reset_mid;
    int lat, d0;
    d0 = done_cnt;
    issue(2'b11, 1'b0, 32'h0100);
    tick;
    reset = 1'b1;
    #1;
    checks++; if ({mem_rd, mem_addr, ld_busy, ld_done, ld_data, ld_exc, ld_exc_code} !== 69'd0)
      $display("FAIL reset_mid_outputs: got %h, want 0", {mem_rd, mem_addr, ld_busy, ld_done, ld_data, ld_exc, ld_exc_code}); else passed++;
    last_data = '0;
    tick;
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    tick;
    mem_ack = 1'b0;
    tick; tick;
    checks++; if ({mem_rd, ld_busy, ld_data, done_cnt - d0} !== {2'b00, 32'h0, 32'd0})
      $display("FAIL late_ack_ignored: got %b/%h dones=%0d, want 00/00000000/0", {mem_rd, ld_busy}, ld_data, done_cnt - d0); else passed++;
    push_exp(32'h0000_005A, 2'd0);
    issue(2'b01, 1'b0, 32'h0007);
    respond(0, 32'h5A00_0000);
    wait_done(lat);
    checks++; if (lat !== 1) $display("FAIL recover_latency: got %0d, want 1", lat); else passed++;
    tick;
  endtask

  initial begin
    test_reset;
    test_extract;
    test_misalign;
    test_reserved;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    checks++; if (sb.size() !== 0) $display("FAIL sb_drained: got %0d pending, want 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
